// File: rtl/key_event_decoder.sv
// Matrix-keyboard event decoder: debounces scan frames, emits press/release events into a FIFO.
// Define KEY_EVENT_DECODER_REPEAT_EN to enable single-key auto-repeat and the overflow flag.
module key_event_decoder #(
  parameter int KEYS         = 20,
  parameter int DEBOUNCE     = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10,
  localparam int CW          = (KEYS > 1) ? $clog2(KEYS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [KEYS-1:0] scan_result,
  input  logic            scan_valid,
  output logic            key_valid,
  output logic [CW-1:0]   key_code,
  output logic            key_press,
  input  logic            key_ready,
  output logic [KEYS-1:0] key_state,
  output logic            overflow
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam int            AW       = $clog2(FIFO_DEPTH);
  localparam logic [2:0]    DB_MAX   = 3'(DEBOUNCE - 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(KEYS - 1);

  state_t          state, state_next;
  logic [KEYS-1:0] last_sample, stable_frame, target;
  logic [2:0]      match_cnt;
  logic            frame_match, frame_accept;
  logic [CW-1:0]   idx;

  logic [CW:0]     fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            fifo_full, push_en, pop_en;
  logic [CW:0]     push_data, head;

  logic            scan_push_req, scan_push, scan_advance;
  logic            rpt_push;
  logic [CW-1:0]   rpt_code;

  assign frame_match  = (scan_result == last_sample);
  assign frame_accept = scan_valid &&
                        ((DEBOUNCE == 1) ||
                         (frame_match && (({1'b0, match_cnt} + 4'd1) >= {1'b0, DB_MAX})));

  always_ff @(posedge clk) begin
    if (rst) begin
      last_sample  <= '0;
      match_cnt    <= '0;
      stable_frame <= '0;
    end else if (scan_valid) begin
      last_sample <= scan_result;
      if (!frame_match)
        match_cnt <= '0;
      else if (match_cnt < DB_MAX)
        match_cnt <= match_cnt + 3'd1;
      if (frame_accept)
        stable_frame <= scan_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (stable_frame != key_state) state_next = SCAN;
      SCAN:    if (scan_advance && (idx == LAST_IDX)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A changed key that finds the FIFO full holds idx, so nothing is ever dropped.
  always_comb begin
    scan_push_req = 1'b0;
    scan_push     = 1'b0;
    scan_advance  = 1'b0;
    if (state == SCAN) begin
      scan_push_req = (target[idx] != key_state[idx]);
      scan_push     = scan_push_req && !fifo_full;
      scan_advance  = !scan_push_req || !fifo_full;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      target    <= '0;
      idx       <= '0;
      key_state <= '0;
    end else if ((state == IDLE) && (state_next == SCAN)) begin
      target <= stable_frame;
      idx    <= '0;
    end else if (scan_advance) begin
      if (scan_push)
        key_state[idx] <= target[idx];
      if (idx != LAST_IDX)
        idx <= idx + CW'(1);
    end
  end

`ifdef KEY_EVENT_DECODER_REPEAT_EN
  localparam int RW = $clog2(((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE) + 1);

  logic [RW-1:0] rpt_cnt, rpt_target;
  logic          rpt_armed, single_key, rpt_fire;

  assign single_key = (key_state != '0) && ((key_state & (key_state - KEYS'(1))) == '0);
  assign rpt_target = rpt_armed ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY);
  assign rpt_fire   = frame_accept && (state == IDLE) && single_key &&
                      ((rpt_cnt + RW'(1)) == rpt_target);
  assign rpt_push   = rpt_fire && !fifo_full;

  always_comb begin
    rpt_code = '0;
    for (int i = 0; i < KEYS; i++)
      if (key_state[i]) rpt_code = CW'(i);
  end

  always_ff @(posedge clk) begin
    if (rst || (state != IDLE) || !single_key) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
    end else if (frame_accept) begin
      if (rpt_fire) begin
        rpt_cnt   <= '0;
        rpt_armed <= 1'b1;
      end else begin
        rpt_cnt <= rpt_cnt + RW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      overflow <= 1'b0;
    else if (rpt_fire && fifo_full)
      overflow <= 1'b1;
  end
`else
  localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_RATE;

  assign rpt_push = 1'b0;
  assign rpt_code = '0;
  assign overflow = 1'b0;
`endif

  // Scan and repeat pushes never collide: repeats only fire in IDLE.
  assign push_en   = scan_push || rpt_push;
  assign push_data = scan_push ? {target[idx], idx} : {1'b1, rpt_code};
  assign fifo_full = (count == (AW+1)'(FIFO_DEPTH));
  assign key_valid = (count != '0);
  assign pop_en    = key_valid && key_ready;
  assign head      = fifo_mem[rd_ptr];
  assign key_code  = key_valid ? head[CW-1:0] : '0;
  assign key_press = key_valid && head[CW];

  always_ff @(posedge clk) begin
    if (push_en)
      fifo_mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_en, pop_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Self-checking bench for key_event_decoder: table-driven frames plus an event scoreboard.
// Repeat scenarios run only when KEY_EVENT_DECODER_REPEAT_EN is defined.
module tb_key_event_decoder;

  localparam int KEYS = 20;
  localparam int CW   = 5;
  localparam int RD   = 3;
  localparam int RR   = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [KEYS-1:0] scan_result;
  logic            scan_valid;
  logic            key_valid;
  logic [CW-1:0]   key_code;
  logic            key_press;
  logic            key_ready;
  logic [KEYS-1:0] key_state;
  logic            overflow;

  key_event_decoder #(
    .KEYS(KEYS), .DEBOUNCE(2), .FIFO_DEPTH(4), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .rst(rst), .scan_result(scan_result), .scan_valid(scan_valid),
    .key_valid(key_valid), .key_code(key_code), .key_press(key_press),
    .key_ready(key_ready), .key_state(key_state), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [KEYS-1:0] frame;
    logic [KEYS-1:0] exp_state;
  } vec_t;

  typedef struct {
    int   code;
    logic press;
  } ev_t;

  ev_t             exp_q[$];
  vec_t            vecs[14];
  logic [KEYS-1:0] exp_state;
  int              checks = 0;
  int              errors = 0;
  int              cycle = 0;
  int              pop_count = 0;
  int              first_pop = -1;
  int              last_pop = -1;

  always @(posedge clk) cycle++;

  // Every accepted event is matched against the oldest expected one.
  always @(negedge clk) begin
    if (!rst && key_valid && key_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_event code=%0d press=%0d required=none", key_code, key_press);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (key_code !== CW'(e.code) || key_press !== e.press) begin
          errors++;
          $display("[TB] FAIL event code=%0d press=%0d required code=%0d press=%0d",
                   key_code, key_press, e.code, e.press);
        end
      end
      pop_count++;
      if (first_pop < 0) first_pop = cycle;
      last_pop = cycle;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendFrame(input logic [KEYS-1:0] f);
    @(posedge clk);
    #1;
    scan_result = f;
    scan_valid  = 1'b1;
    @(posedge clk);
    #1;
    scan_valid = 1'b0;
  endtask

  task automatic expectTransition(input logic [KEYS-1:0] nxt);
    for (int i = 0; i < KEYS; i++)
      if (nxt[i] != exp_state[i]) exp_q.push_back('{code: i, press: nxt[i]});
    exp_state = nxt;
  endtask

  task automatic applyStimulus(input vec_t v);
    sendFrame(v.frame);
    expectTransition(v.exp_state);
    settle(30);
  endtask

  task automatic doReset();
    rst = 1'b1;
    settle(2);
    rst = 1'b0;
    exp_q.delete();
    exp_state = '0;
  endtask

  initial begin
    vecs[0]  = '{20'h00004, 20'h00000};
    vecs[1]  = '{20'h00004, 20'h00004};
    vecs[2]  = '{20'h00000, 20'h00004};
    vecs[3]  = '{20'h00000, 20'h00000};
    vecs[4]  = '{20'h00010, 20'h00000};
    vecs[5]  = '{20'h00000, 20'h00000};
    vecs[6]  = '{20'h00010, 20'h00000};
    vecs[7]  = '{20'h00000, 20'h00000};
    vecs[8]  = '{20'h80005, 20'h00000};
    vecs[9]  = '{20'h80005, 20'h80005};
    vecs[10] = '{20'h80001, 20'h80005};
    vecs[11] = '{20'h80001, 20'h80001};
    vecs[12] = '{20'h00000, 20'h80001};
    vecs[13] = '{20'h00000, 20'h00000};

    scan_result = '0;
    scan_valid  = 1'b0;
    key_ready   = 1'b1;
    exp_state   = '0;
    #1;
    doReset();
    checkOutput("rst_key_valid", 32'(key_valid), 32'd0);
    checkOutput("rst_key_state", 32'(key_state), 32'd0);
    checkOutput("rst_overflow",  32'(overflow),  32'd0);
    checkOutput("rst_key_code",  32'(key_code),  32'd0);
    checkOutput("rst_key_press", 32'(key_press), 32'd0);

    for (int v = 0; v < 14; v++) begin
      applyStimulus(vecs[v]);
      checkOutput($sformatf("vec%0d_key_state", v), 32'(key_state), 32'(vecs[v].exp_state));
      checkOutput($sformatf("vec%0d_pending", v), 32'(exp_q.size()), 32'd0);
    end

    // FIFO fills with four presses, then the SCAN stalls at idx 16.
    key_ready = 1'b0;
    sendFrame(20'h0000F);
    sendFrame(20'h0000F);
    expectTransition(20'h0000F);
    settle(30);
    checkOutput("full_key_valid", 32'(key_valid), 32'd1);
    checkOutput("full_head_code", 32'(key_code),  32'd0);
    checkOutput("full_head_press", 32'(key_press), 32'd1);
    checkOutput("full_key_state", 32'(key_state), 32'h0000F);
    sendFrame(20'h1000F);
    sendFrame(20'h1000F);
    expectTransition(20'h1000F);
    settle(30);
    checkOutput("stall_key_state", 32'(key_state), 32'h0000F);
    key_ready = 1'b1;
    settle(30);
    checkOutput("stall_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("stall_key_state_final", 32'(key_state), 32'h1000F);
    checkOutput("stall_overflow", 32'(overflow), 32'd0);

    sendFrame(20'h00000);
    sendFrame(20'h00000);
    expectTransition(20'h00000);
    settle(30);
    checkOutput("release_drained", 32'(exp_q.size()), 32'd0);

    // All 20 presses stream out one per cycle with the consumer always ready.
    pop_count = 0;
    first_pop = -1;
    sendFrame(20'hFFFFF);
    sendFrame(20'hFFFFF);
    expectTransition(20'hFFFFF);
    settle(40);
    checkOutput("stream_pops", 32'(pop_count), 32'd20);
    checkOutput("stream_span", 32'(last_pop - first_pop), 32'd19);
    checkOutput("stream_key_state", 32'(key_state), 32'hFFFFF);
    sendFrame(20'h00000);
    sendFrame(20'h00000);
    expectTransition(20'h00000);
    settle(40);
    checkOutput("stream_release", 32'(key_state), 32'h00000);

    // Reset mid-SCAN, then the held keys are re-reported after debounce.
    key_ready = 1'b0;
    sendFrame(20'hFFFFF);
    sendFrame(20'hFFFFF);
    settle(6);
    doReset();
    checkOutput("midscan_rst_valid", 32'(key_valid), 32'd0);
    checkOutput("midscan_rst_state", 32'(key_state), 32'd0);
    sendFrame(20'hFFFFF);
    sendFrame(20'hFFFFF);
    expectTransition(20'hFFFFF);
    @(negedge clk);
    checkOutput("latency_c0", 32'(key_valid), 32'd0);
    @(negedge clk);
    checkOutput("latency_c1", 32'(key_valid), 32'd0);
    @(negedge clk);
    checkOutput("latency_c2", 32'(key_valid), 32'd1);
    checkOutput("latency_code", 32'(key_code), 32'd0);
    settle(1);
    key_ready = 1'b1;
    settle(40);
    checkOutput("recover_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("recover_state", 32'(key_state), 32'hFFFFF);
    sendFrame(20'h00000);
    sendFrame(20'h00000);
    expectTransition(20'h00000);
    settle(40);
    checkOutput("recover_release", 32'(key_state), 32'h00000);

`ifdef KEY_EVENT_DECODER_REPEAT_EN
    sendFrame(20'h00020);
    sendFrame(20'h00020);
    expectTransition(20'h00020);
    settle(30);
    for (int n = 1; n <= 17; n++) begin
      if (n == 8) key_ready = 1'b0;
      sendFrame(20'h00020);
      if ((n == RD || (n > RD && ((n - RD) % RR) == 0)) && n < 17)
        exp_q.push_back('{code: 5, press: 1'b1});
      settle(30);
    end
    checkOutput("repeat_overflow", 32'(overflow), 32'd1);
    checkOutput("repeat_full_valid", 32'(key_valid), 32'd1);
    key_ready = 1'b1;
    settle(10);
    checkOutput("repeat_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("repeat_overflow_sticky", 32'(overflow), 32'd1);
    doReset();
    checkOutput("repeat_overflow_rst", 32'(overflow), 32'd0);
`endif

    checkOutput("final_pending", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
Consumes the 20-bit matrix-keyboard snapshot from the keyboard scanner.
- Debounces snapshots across scan frames.
- Compares the debounced state with the committed key state and encodes each changed key as a press or release event.
- Queues events in a small FIFO with a valid/ready handshake toward the CPU/IO bus.

Parameters:
KEYS, 20, number of key bits in scan_result; code width is 5 bits for the default value.
DEBOUNCE, 2, number of consecutive identical frames (1..7) required before a frame is accepted.
FIFO_DEPTH, 4, event FIFO entries; must be a power of 2.
REPEAT_DELAY, 50, frames a single key must be held before the first repeat (used only with the optional feature).
REPEAT_RATE, 10, frames between subsequent repeats (used only with the optional feature).

Ports:
clk  in  1  main clock
rst  in  1  reset, synchronous, active-high
scan_result  in  KEYS  latest scan frame, 1 = key pressed
scan_valid  in  1  one-cycle strobe; scan_result holds a complete new frame
key_valid  out  1  FIFO head is valid
key_code  out  5  key index 0..KEYS-1 of the head event
key_press  out  1  1 = press, 0 = release
key_ready  in  1  consumer accepts the head event
key_state  out  KEYS  committed debounced key state
overflow  out  1  sticky flag; cleared only by rst

Behaviour:
- Reset values:
  - Outputs: key_valid=0, key_code=0, key_press=0, key_state=0, overflow=0.
  - Internal: FIFO empty, FSM=IDLE, last_sample=0, match_cnt=0, stable_frame=0.
- Debounce (updates only on cycles with scan_valid=1):
  - If scan_result==last_sample, match_cnt increments, saturating at DEBOUNCE-1. Otherwise match_cnt is set to 0.
  - last_sample <= scan_result.
  - If scan_result==last_sample and match_cnt+1 >= DEBOUNCE-1, then stable_frame <= scan_result.
  - DEBOUNCE=1: every frame is accepted.
- FSM IDLE:
  - If stable_frame != key_state: target <= stable_frame, idx <= 0, go to SCAN.
- FSM SCAN (one bit per cycle, ascending idx 0..KEYS-1):
  - If target[idx]==key_state[idx]: idx++.
  - Else, if the FIFO is not full: push {press=target[idx], code=idx}, key_state[idx] <= target[idx], idx++.
  - Else (FIFO full): hold idx. No event is lost.
  - When idx reaches KEYS-1 and that bit is handled: go to IDLE.
- stable_frame changes during SCAN do not affect target. They are picked up on the next return to IDLE.
- Minimum SCAN duration is KEYS cycles. A frame difference is first visible as key_valid=1 two cycles after stable_frame updates, if the lowest changed bit is idx 0.
- FIFO:
  - key_valid = FIFO not empty; key_code and key_press show the head entry.
  - Pop occurs when key_valid && key_ready.
  - Push is allowed when count<FIFO_DEPTH, evaluated before the same-cycle pop. A simultaneous push and pop while full is therefore not a push.
  - Simultaneous push and pop while non-empty: count unchanged, order preserved.
- overflow: set only by repeat events that are dropped (optional feature). Normal events stall instead of dropping.
- rst during SCAN: returns to IDLE, empties the FIFO, clears key_state. Keys still held then re-generate press events after DEBOUNCE frames.

Optional Feature:
KEY_EVENT_DECODER_REPEAT_EN
- Defined:
  - While key_state has exactly one bit set and the FSM is IDLE, a frame counter counts accepted frames.
  - After REPEAT_DELAY frames, then every REPEAT_RATE frames, one press event for that key is pushed.
  - If the FIFO is full at that moment, the repeat is dropped and overflow is set.
  - The counter resets on any key_state change or when the number of held keys != 1.
- Undefined: no repeat logic; overflow is tied to 0.

Test Plan:
1. rst=1 for 2 cycles -> key_valid=0, key_state=0, overflow=0.
2. DEBOUNCE=2; frames 0x00004, 0x00004 with key_ready=1 -> one event code=2 press=1; key_state=0x00004. Then frames 0x00000 x2 -> code=2 press=0.
3. Bounce: frames 0x00010, 0x00000, 0x00010, 0x00000 -> no event; key_state stays 0.
4. Frames 0x0000F x2 with key_ready=0, FIFO_DEPTH=4:
   - Four events in order, codes 0,1,2,3, all press.
   - Then frames 0x1000F x2 -> SCAN stalls at idx 16 while full.
   - Raise key_ready -> codes 0,1,2,3, then 16 delivered; no loss; overflow=0.
5. Back-to-back pops with key_ready=1 while SCAN pushes every cycle (frame 0xFFFFF x2) -> 20 press events, codes 0..19 ascending, one per cycle after fill.
6. With KEY_EVENT_DECODER_REPEAT_EN, REPEAT_DELAY=3, REPEAT_RATE=2, key 5 held:
   - Initial press, then repeat presses after 3 frames and every 2 frames thereafter.
   - Hold key_ready=0 until full -> overflow=1 and stays set until rst.
